// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, one access per 3 cycles.
// Optional fetch anti-starvation counter enabled by defining ARB_FAIR_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic              ls_rw,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                src_fetch_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   ls_rdata_q;
  logic                any_req;
  logic                grant_fetch;
  logic                arb_en;
  logic                resp_rd;

  assign any_req = if_req | ls_req;
  assign arb_en  = (state_q == StIdle) && any_req;

`ifdef ARB_FAIR_EN
  logic [2:0] starve_q;
  logic       fetch_boost;

  assign fetch_boost = (starve_q == 3'(STARVE_MAX));
  assign grant_fetch = if_req && (!ls_req || fetch_boost);

  // Counts data grants that overtook a waiting fetch; saturates at 7.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= 3'd0;
    end else if (!if_req) begin
      starve_q <= 3'd0;
    end else if (arb_en) begin
      if (grant_fetch) begin
        starve_q <= 3'd0;
      end else if (starve_q != 3'd7) begin
        starve_q <= starve_q + 3'd1;
      end
    end
  end
`else
  logic unused_starve_max;

  // Keeps the parameter referenced in the fixed-priority build.
  assign unused_starve_max = ^STARVE_MAX;
  assign grant_fetch       = if_req && !ls_req;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Winner's operands are frozen here; requester inputs are ignored until the next IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_fetch_q <= 1'b0;
      rw_q        <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else if (arb_en) begin
      src_fetch_q <= grant_fetch;
      rw_q        <= grant_fetch | ls_rw;
      addr_q      <= grant_fetch ? if_addr : ls_addr;
      wdata_q     <= grant_fetch ? '0 : ls_wdata;
    end
  end

  assign resp_rd = (state_q == StResp) && rw_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else if (resp_rd) begin
      if (src_fetch_q) begin
        if_rdata_q <= ram_rdata;
      end else begin
        ls_rdata_q <= ram_rdata;
      end
    end
  end

  // RAM data arrives in RESP; forward it so rdata is valid alongside the valid pulse,
  // then the hold register keeps it until the next read for that requester.
  assign if_rdata  = (resp_rd && src_fetch_q) ? ram_rdata : if_rdata_q;
  assign ls_rdata  = (resp_rd && !src_fetch_q) ? ram_rdata : ls_rdata_q;
  assign if_valid  = (state_q == StResp) && src_fetch_q;
  assign ls_valid  = (state_q == StResp) && !src_fetch_q;

  assign ram_en    = (state_q == StAccess);
  assign ram_rw    = rw_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a synchronous single-port RAM model.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        ls_req;
  logic        ls_rw;
  logic [15:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_valid;
  logic        ram_en;
  logic        ram_rw;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  logic [31:0] mem [0:65535];
  int          pass_cnt;
  int          total_cnt;

  mem_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .ls_req   (ls_req),
    .ls_rw    (ls_rw),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_rdata (ls_rdata),
    .ls_valid (ls_valid),
    .ram_en   (ram_en),
    .ram_rw   (ram_rw),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_rw) ram_rdata <= mem[ram_addr];
      else        mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_rw = 1'b1;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) cyc();
    total_cnt++;
    if ({busy, ram_en, ram_rw, if_valid, ls_valid} !== 5'b00100)
      $display("FAIL reset_ctrl: got %b want 00100", {busy, ram_en, ram_rw, if_valid, ls_valid});
    else pass_cnt++;
    total_cnt++;
    if ({ram_addr, ram_wdata, if_rdata, ls_rdata} !== '0)
      $display("FAIL reset_data: addr %h wdata %h if_rdata %h ls_rdata %h want all 0",
               ram_addr, ram_wdata, if_rdata, ls_rdata);
    else pass_cnt++;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_fetch();
    mem[16'h0010] = 32'hE3A01005;
    ls_rw = 1'b0;
    if_req = 1'b1; if_addr = 16'h0010;
    cyc();
    total_cnt++;
    if ({ram_en, ram_rw, busy, if_valid} !== 4'b1110)
      $display("FAIL fetch_access: en/rw/busy/valid got %b want 1110", {ram_en, ram_rw, busy, if_valid});
    else pass_cnt++;
    total_cnt++;
    if (ram_addr !== 16'h0010) $display("FAIL fetch_addr: got %h want 0010", ram_addr);
    else pass_cnt++;
    if_addr = 16'hFFFF;
    cyc();
    total_cnt++;
    if ({if_valid, ls_valid, ram_en} !== 3'b100)
      $display("FAIL fetch_valid: if/ls/en got %b want 100", {if_valid, ls_valid, ram_en});
    else pass_cnt++;
    total_cnt++;
    if (if_rdata !== 32'hE3A01005) $display("FAIL fetch_rdata: got %h want e3a01005", if_rdata);
    else pass_cnt++;
    if_req = 1'b0;
    cyc();
    total_cnt++;
    if ({if_valid, busy} !== 2'b00 || if_rdata !== 32'hE3A01005)
      $display("FAIL fetch_hold: valid %b busy %b rdata %h want 0 0 e3a01005", if_valid, busy, if_rdata);
    else pass_cnt++;
    ls_rw = 1'b1;
  endtask

  task automatic test_store_load();
    ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 16'h0100; ls_wdata = 32'hDEADBEEF;
    cyc();
    total_cnt++;
    if ({ram_en, ram_rw} !== 2'b10 || ram_addr !== 16'h0100 || ram_wdata !== 32'hDEADBEEF)
      $display("FAIL store_access: en %b rw %b addr %h wdata %h want 1 0 0100 deadbeef",
               ram_en, ram_rw, ram_addr, ram_wdata);
    else pass_cnt++;
    ls_wdata = 32'h0;
    cyc();
    total_cnt++;
    if ({ls_valid, if_valid} !== 2'b10 || ls_rdata !== 32'h0)
      $display("FAIL store_valid: ls/if %b rdata %h want 10 00000000", {ls_valid, if_valid}, ls_rdata);
    else pass_cnt++;
    ls_rw = 1'b1;
    cyc();
    total_cnt++;
    if (ls_valid !== 1'b0 || ls_rdata !== 32'h0)
      $display("FAIL store_rdata_kept: valid %b rdata %h want 0 00000000", ls_valid, ls_rdata);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if ({ram_en, ram_rw} !== 2'b11) $display("FAIL load_access: en/rw got %b want 11", {ram_en, ram_rw});
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (ls_valid !== 1'b1 || ls_rdata !== 32'hDEADBEEF)
      $display("FAIL load_valid: valid %b rdata %h want 1 deadbeef", ls_valid, ls_rdata);
    else pass_cnt++;
    ls_req = 1'b0;
    cyc();
    total_cnt++;
    if (ls_valid !== 1'b0 || ls_rdata !== 32'hDEADBEEF)
      $display("FAIL load_hold: valid %b rdata %h want 0 deadbeef", ls_valid, ls_rdata);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    mem[16'h0020] = 32'h11112222;
    mem[16'h0030] = 32'h33334444;
    if_req = 1'b1; if_addr = 16'h0020;
    ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 16'h0030;
    cyc();
    total_cnt++;
    if (ram_addr !== 16'h0030) $display("FAIL prio_first_addr: got %h want 0030", ram_addr);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if ({ls_valid, if_valid} !== 2'b10 || ls_rdata !== 32'h33334444)
      $display("FAIL prio_data_first: ls/if %b rdata %h want 10 33334444", {ls_valid, if_valid}, ls_rdata);
    else pass_cnt++;
    ls_req = 1'b0;
    cyc();
    total_cnt++;
    if ({busy, ls_valid, if_valid} !== 3'b000)
      $display("FAIL prio_idle: busy/ls/if got %b want 000", {busy, ls_valid, if_valid});
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (ram_addr !== 16'h0020 || ram_rw !== 1'b1)
      $display("FAIL prio_second_addr: addr %h rw %b want 0020 1", ram_addr, ram_rw);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if ({if_valid, ls_valid} !== 2'b10 || if_rdata !== 32'h11112222)
      $display("FAIL prio_fetch_next: if/ls %b rdata %h want 10 11112222", {if_valid, ls_valid}, if_rdata);
    else pass_cnt++;
    if_req = 1'b0;
    cyc();
  endtask

  task automatic test_starve();
    int ev [8];
    int exp_ev [6];
    int n;
    int both;
    logic [31:0] exp_if;
    n = 0; both = 0;
`ifdef ARB_FAIR_EN
    exp_ev = '{0, 0, 0, 0, 1, 0};
    exp_if = 32'h66666666;
`else
    exp_ev = '{0, 0, 0, 0, 0, 0};
    exp_if = 32'h11112222;
`endif
    mem[16'h0040] = 32'h55555555;
    mem[16'h0050] = 32'h66666666;
    ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 16'h0040;
    if_req = 1'b1; if_addr = 16'h0050;
    for (int c = 0; c < 18; c++) begin
      cyc();
      if (if_valid && ls_valid) both++;
      if (ls_valid && n < 8) begin
        ev[n] = 0; n++;
      end
      if (if_valid && n < 8) begin
        ev[n] = 1; n++;
        if_req = 1'b0;
      end
    end
    total_cnt++;
    if (n !== 6) $display("FAIL starve_count: got %0d grants want 6", n);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (i >= n || ev[i] !== exp_ev[i])
        $display("FAIL starve_order[%0d]: got %0d want %0d", i, (i < n) ? ev[i] : -1, exp_ev[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (both !== 0) $display("FAIL starve_exclusive: both valids in %0d cycles want 0", both);
    else pass_cnt++;
    total_cnt++;
    if (if_rdata !== exp_if || ls_rdata !== 32'h55555555)
      $display("FAIL starve_rdata: if %h ls %h want %h 55555555", if_rdata, ls_rdata, exp_if);
    else pass_cnt++;
    if_req = 1'b0; ls_req = 1'b0;
    for (int c = 0; c < 6 && busy; c++) cyc();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL starve_drain: busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 16'h0100;
    cyc();
    total_cnt++;
    if (ram_en !== 1'b1) $display("FAIL abort_in_access: ram_en got %b want 1", ram_en);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({ram_en, busy, ls_valid, ram_rw} !== 4'b0001 || ls_rdata !== 32'h0 || ram_addr !== 16'h0)
      $display("FAIL abort_async: en/busy/valid/rw %b rdata %h addr %h want 0001 00000000 0000",
               {ram_en, busy, ls_valid, ram_rw}, ls_rdata, ram_addr);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (ls_valid !== 1'b0) $display("FAIL abort_no_valid: got %b want 0", ls_valid);
    else pass_cnt++;
    reset_n = 1'b1;
    cyc();
    total_cnt++;
    if (ram_en !== 1'b1 || ram_addr !== 16'h0100)
      $display("FAIL abort_retry_access: en %b addr %h want 1 0100", ram_en, ram_addr);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (ls_valid !== 1'b1 || ls_rdata !== 32'hDEADBEEF)
      $display("FAIL abort_retry_valid: valid %b rdata %h want 1 deadbeef", ls_valid, ls_rdata);
    else pass_cnt++;
    ls_req = 1'b0;
    cyc();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    ram_rdata = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_starve();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
